uart_block_sequencer: RTL and testbench

//  Serialises one multi-byte block (default 128-bit AES ciphertext) through the uart_tx byte transmitter.

---
 rtl/uart_block_sequencer_if.sv | 21 ++
 rtl/uart_block_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_uart_block_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_block_sequencer_if.sv
// Block handshake between the AES core (master) and the UART block sequencer (slave).
// Signals: blk_valid (block offered), blk_data (8*NUM_BYTES block, MSB byte first), blk_ready (accept).
interface uart_block_sequencer_if #(
    parameter int unsigned NUM_BYTES = 16
);
    logic                   blk_valid;
    logic [8*NUM_BYTES-1:0] blk_data;
    logic                   blk_ready;

    modport master (
        output blk_valid,
        output blk_data,
        input  blk_ready
    );

    modport slave (
        input  blk_valid,
        input  blk_data,
        output blk_ready
    );
endinterface

// File: rtl/uart_block_sequencer.sv
// Serialises one multi-byte block through uart_tx as header, data MSB first, optional XOR checksum.
// Ports: uart_clock, uart_reset (async, active-low), blk (slave handshake), tx_start/tx_byte to uart_tx,
// tx_ready_in from uart_tx, busy, done (1-cycle pulse), err (sticky ack timeout).
// Optional feature: define UART_SEQ_CHECKSUM_EN to append the XOR of the data bytes as a final byte.
module uart_block_sequencer #(
    parameter int unsigned NUM_BYTES   = 16,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                  uart_clock,
    input  logic                  uart_reset,
    uart_block_sequencer_if.slave blk,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned DW = 8 * NUM_BYTES;
    localparam int unsigned IW = $clog2(NUM_BYTES + 3);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int unsigned LAST_IDX = NUM_BYTES + 1;
`else
    localparam int unsigned LAST_IDX = NUM_BYTES;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] to_q, to_d;
    logic          start_q, start_d;
    logic [7:0]    byte_q, byte_d;
    logic          err_q, err_d;
    logic          done_c;
    logic          is_last;
    logic          is_data;
    logic [7:0]    cur_byte;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    // idx 0 is the header, 1..NUM_BYTES the data, NUM_BYTES+1 the checksum.
    assign is_last = (idx_q == IW'(LAST_IDX));
    assign is_data = (idx_q != '0) && (idx_q <= IW'(NUM_BYTES));

    always_comb begin
        cur_byte = 8'h00;
        if (idx_q == '0) begin
            cur_byte = HEADER_BYTE;
        end else if (is_data) begin
            cur_byte = shreg_q[DW-1 -: 8];
        end else begin
`ifdef UART_SEQ_CHECKSUM_EN
            cur_byte = csum_q;
`else
            cur_byte = 8'h00;
`endif
        end
    end

    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            to_q    <= '0;
            start_q <= 1'b0;
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            start_q <= start_d;
            byte_q  <= byte_d;
            err_q   <= err_d;
        end
    end

`ifdef UART_SEQ_CHECKSUM_EN
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        to_d    = to_q;
        start_d = start_q;
        byte_d  = byte_q;
        err_d   = err_q;
        done_c  = 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (blk.blk_valid) begin
                    shreg_d = blk.blk_data;
                    idx_d   = '0;
                    gap_d   = '0;
                    err_d   = 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // The gap only advances while uart_tx is idle, so a
                // slow transmitter stretches it rather than shortening it.
                if (tx_ready_in) begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        state_d = S_ISSUE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            S_ISSUE: begin
                byte_d  = cur_byte;
                start_d = 1'b1;
                to_d    = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!tx_ready_in) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else if (to_q == TW'(ACK_TIMEOUT - 1)) begin
                    // Abandon the packet; remaining bytes are dropped.
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_ready_in) begin
                    if (is_data) begin
`ifdef UART_SEQ_CHECKSUM_EN
                        csum_d = csum_q ^ shreg_q[DW-1 -: 8];
`endif
                        shreg_d = shreg_q << 8;
                    end
                    if (is_last) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // done is raised while still leaving WAIT_DONE, so a block offered in
    // that cycle is only accepted once the state has reached IDLE.
    assign blk.blk_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_c;
    assign err           = err_q;
    assign tx_start      = start_q;
    assign tx_byte       = byte_q;

endmodule

// File: tb/tb_uart_block_sequencer.sv
// Self-checking bench for uart_block_sequencer with a behavioural uart_tx stub.
// Byte stream is compared against a queue-based packet model built from the block.
`timescale 1ns/1ps
module tb_uart_block_sequencer;

    localparam int NB   = 16;
    localparam int GAP  = 2;
    localparam int TOUT = 1024;
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int PLEN = NB + 2;
`else
    localparam int PLEN = NB + 1;
`endif

    logic            uart_clock  = 1'b0;
    logic            uart_reset  = 1'b0;
    logic            tx_start;
    logic [7:0]      tx_byte;
    logic            tx_ready_in = 1'b1;
    logic            busy;
    logic            done;
    logic            err;

    uart_block_sequencer_if #(.NUM_BYTES(NB)) bif ();

    uart_block_sequencer #(
        .NUM_BYTES   (NB),
        .HEADER_BYTE (8'hA5),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TOUT)
    ) dut (
        .uart_clock  (uart_clock),
        .uart_reset  (uart_reset),
        .blk         (bif),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_ready_in (tx_ready_in),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #10 uart_clock = ~uart_clock;

    // uart_tx stub and line monitor (monitor samples before stub updates)
    logic [7:0] rx_q[$];
    int         gap_q[$];
    bit         stab_q[$];
    bit         mute      = 1'b0;
    int         low_cnt   = 1000;
    bit         prev_st   = 1'b0;
    bit         locked    = 1'b0;
    bit         stab_bad  = 1'b0;
    logic [7:0] lock_byte = 8'h00;
    bit         pend      = 1'b0;
    int         bcnt      = 0;

    always @(negedge uart_clock) begin
        if (tx_start && !prev_st) begin
            gap_q.push_back(low_cnt);
            locked    = 1'b1;
            stab_bad  = 1'b0;
            lock_byte = tx_byte;
        end else if (locked) begin
            if (tx_byte !== lock_byte) stab_bad = 1'b1;
            if (!tx_start && tx_ready_in) begin
                stab_q.push_back(stab_bad);
                locked = 1'b0;
            end
        end
        low_cnt = tx_start ? 0 : low_cnt + 1;
        if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) tx_ready_in = 1'b1;
        end else if (pend) begin
            rx_q.push_back(tx_byte);
            tx_ready_in = 1'b0;
            bcnt = $urandom_range(8, 2);
            pend = 1'b0;
        end else if (!mute && tx_ready_in && tx_start && !prev_st) begin
            pend = 1'b1;
        end
        prev_st = tx_start;
    end

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [8*NB-1:0] data;
        logic [7:0]      exp_first;
        logic [7:0]      exp_last;
        int              exp_len;
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge uart_clock);
        #2;
    endtask

    function automatic void model(input logic [8*NB-1:0] d);
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = NB - 1; i >= 0; i--) begin
            exp_q.push_back(d[8*i +: 8]);
            x = x ^ d[8*i +: 8];
        end
`ifdef UART_SEQ_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    task automatic accept(input logic [8*NB-1:0] d);
        int n;
        n = 0;
        while (bif.blk_ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("accept_ready", bif.blk_ready, 1);
        bif.blk_data  = d;
        bif.blk_valid = 1'b1;
        tick();
        bif.blk_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (n < 20000) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
        chk({name, "_done_seen"}, ok, 1);
    endtask

    task automatic check_pkt(input string name, input logic [8*NB-1:0] d,
                             input int r0, input int g0, input int s0);
        int bad;
        int gbad;
        int sbad;
        model(d);
        bad = 0;
        chk({name, "_nbytes"}, rx_q.size() - r0, exp_q.size());
        foreach (exp_q[i]) begin
            if (r0 + i >= rx_q.size()) bad++;
            else if (rx_q[r0+i] !== exp_q[i]) bad++;
        end
        chk({name, "_bytes"}, bad, 0);
        gbad = 0;
        for (int i = g0; i < gap_q.size(); i++)
            if (gap_q[i] < GAP) gbad++;
        chk({name, "_rises"}, gap_q.size() - g0, exp_q.size());
        chk({name, "_gap"}, gbad, 0);
        sbad = 0;
        for (int i = s0; i < stab_q.size(); i++)
            if (stab_q[i]) sbad++;
        chk({name, "_stable"}, sbad, 0);
    endtask

    task automatic run_pkt(input string name, input logic [8*NB-1:0] d,
                           output int r0);
        int g0;
        int s0;
        r0 = rx_q.size();
        g0 = gap_q.size();
        s0 = stab_q.size();
        accept(d);
        wait_done(name);
        tick();
        chk({name, "_done_1cyc"}, done, 0);
        check_pkt(name, d, r0, g0, s0);
        chk({name, "_err"}, err, 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_blk_ready"}, bif.blk_ready, 1);
        chk({name, "_tx_start"}, tx_start, 0);
        chk({name, "_tx_byte"}, tx_byte, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_err"}, err, 0);
    endtask

    initial begin
        logic [8*NB-1:0] a;
        logic [8*NB-1:0] b;
        int r0;
        int r1;
        int g0;
        int g1;
        int s0;
        int s1;
        int n;
        int hi;
        int rdy_seen;

        vt[0].data      = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        vt[0].exp_first = 8'h00;
        vt[1].data      = {16{8'h01}};
        vt[1].exp_first = 8'h01;
        vt[2].data      = 128'h01000000_00000000_00000000_00000000;
        vt[2].exp_first = 8'h01;
`ifdef UART_SEQ_CHECKSUM_EN
        vt[0].exp_last = 8'h00;
        vt[1].exp_last = 8'h00;
        vt[2].exp_last = 8'h01;
`else
        vt[0].exp_last = 8'hFF;
        vt[1].exp_last = 8'h01;
        vt[2].exp_last = 8'h00;
`endif
        foreach (vt[i]) vt[i].exp_len = PLEN;

        bif.blk_valid = 1'b0;
        bif.blk_data  = '0;
        #25;
        chk_reset_vals("reset");
        tick();
        uart_reset = 1'b1;
        tick();
        tick();

        // table-driven packets
        for (int i = 0; i < 3; i++) begin
            run_pkt($sformatf("vec%0d", i), vt[i].data, r0);
            chk($sformatf("vec%0d_len", i), rx_q.size() - r0, vt[i].exp_len);
            chk($sformatf("vec%0d_hdr", i), rx_q[r0], 8'hA5);
            chk($sformatf("vec%0d_first", i), rx_q[r0+1], vt[i].exp_first);
            chk($sformatf("vec%0d_last", i), rx_q[r0+PLEN-1], vt[i].exp_last);
        end

        // randomized packets against the model
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            run_pkt($sformatf("rnd%0d", i), a, r0);
        end

        // blk_valid held across two blocks
        a  = {$urandom, $urandom, $urandom, $urandom};
        b  = {$urandom, $urandom, $urandom, $urandom};
        r0 = rx_q.size();
        g0 = gap_q.size();
        s0 = stab_q.size();
        bif.blk_data  = a;
        bif.blk_valid = 1'b1;
        chk("hold_ready_a", bif.blk_ready, 1);
        tick();
        bif.blk_data = b;
        rdy_seen = 0;
        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            if (bif.blk_ready !== 1'b0) rdy_seen++;
            tick();
            n++;
        end
        chk("hold_ready_low_a", rdy_seen, 0);
        chk("hold_a_done", done, 1);
        chk("hold_no_accept_at_done", bif.blk_ready, 0);
        tick();
        chk("hold_ready_after_done", bif.blk_ready, 1);
        chk("hold_busy_after_done", busy, 0);
        check_pkt("hold_a", a, r0, g0, s0);
        r1 = rx_q.size();
        g1 = gap_q.size();
        s1 = stab_q.size();
        tick();
        chk("hold_b_accepted", busy, 1);
        bif.blk_valid = 1'b0;
        wait_done("hold_b");
        tick();
        check_pkt("hold_b", b, r1, g1, s1);

        // ack timeout: stub never drops ready
        mute = 1'b1;
        tick();
        accept(vt[0].data);
        hi = 0;
        n  = 0;
        while (err !== 1'b1 && n < 3000) begin
            if (tx_start === 1'b1) hi++;
            tick();
            n++;
        end
        chk("to_err", err, 1);
        chk("to_start_cycles", hi, TOUT);
        chk("to_busy", busy, 0);
        chk("to_ready", bif.blk_ready, 1);
        mute = 1'b0;
        tick();
        tick();
        a  = {$urandom, $urandom, $urandom, $urandom};
        r0 = rx_q.size();
        g0 = gap_q.size();
        s0 = stab_q.size();
        accept(a);
        chk("to_err_cleared", err, 0);
        wait_done("to_next");
        tick();
        check_pkt("to_next", a, r0, g0, s0);

        // async reset during data byte 7
        a  = {$urandom, $urandom, $urandom, $urandom};
        r0 = rx_q.size();
        accept(a);
        n = 0;
        while (rx_q.size() < r0 + 9 && n < 5000) begin
            tick();
            n++;
        end
        chk("rst_reached_byte7", rx_q.size() >= r0 + 9, 1);
        uart_reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        uart_reset = 1'b1;
        n = 0;
        while (tx_ready_in !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        run_pkt("after_rst", vt[0].data, r0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
